// File: rtl/apb_node_timeout.sv
// APB 1-to-N node: address decode, slave routing, decode-error response and a
// per-transfer watchdog. Optional error capture registers under APB_NODE_ERR_CAPTURE_EN.
module apb_node_timeout #(
   parameter int NB_MASTER      = 10,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter logic [NB_MASTER*APB_ADDR_WIDTH-1:0] START_ADDR = {
      32'h1A10_9000, 32'h1A10_8000, 32'h1A10_7000, 32'h1A10_6000, 32'h1A10_5000,
      32'h1A10_4000, 32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000},
   parameter logic [NB_MASTER*APB_ADDR_WIDTH-1:0] END_ADDR = {
      32'h1A10_9FFF, 32'h1A10_8FFF, 32'h1A10_7FFF, 32'h1A10_6FFF, 32'h1A10_5FFF,
      32'h1A10_4FFF, 32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF},
   parameter int TIMEOUT_CYCLES = 256
) (
`ifdef APB_NODE_ERR_CAPTURE_EN
   output logic                                 err_valid_o,
   output logic [APB_ADDR_WIDTH-1:0]            err_addr_o,
   output logic                                 err_timeout_o,
   input  logic                                 err_clr_i,
`endif
   input  logic                                 HCLK,
   input  logic                                 HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]            s_paddr,
   input  logic [APB_DATA_WIDTH-1:0]            s_pwdata,
   input  logic                                 s_pwrite,
   input  logic                                 s_psel,
   input  logic                                 s_penable,
   output logic [APB_DATA_WIDTH-1:0]            s_prdata,
   output logic                                 s_pready,
   output logic                                 s_pslverr,
   output logic [APB_ADDR_WIDTH-1:0]            m_paddr,
   output logic [APB_DATA_WIDTH-1:0]            m_pwdata,
   output logic                                 m_pwrite,
   output logic [NB_MASTER-1:0]                 m_psel,
   output logic [NB_MASTER-1:0]                 m_penable,
   input  logic [NB_MASTER*APB_DATA_WIDTH-1:0]  m_prdata,
   input  logic [NB_MASTER-1:0]                 m_pready,
   input  logic [NB_MASTER-1:0]                 m_pslverr
);

   localparam int IW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_LIM = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ABORT  = 2'd2
   } state_t;

   state_t                    state_r, state_nxt_s;
   logic [IW-1:0]             idx_r, dec_idx_s;
   logic                      miss_r, hit_s;
   logic [CW-1:0]             cnt_r;
   logic                      sel_rdy_s, sel_err_s;
   logic [APB_DATA_WIDTH-1:0] sel_rdata_s;

   assign m_paddr     = s_paddr;
   assign m_pwdata    = s_pwdata;
   assign m_pwrite    = s_pwrite;
   assign sel_rdy_s   = m_pready[idx_r];
   assign sel_err_s   = m_pslverr[idx_r];
   assign sel_rdata_s = m_prdata[idx_r*APB_DATA_WIDTH +: APB_DATA_WIDTH];

   // Address decode; descending scan so the lowest matching region wins
   always_comb begin
      hit_s     = 1'b0;
      dec_idx_s = '0;
      for (int i = NB_MASTER - 1; i >= 0; i--) begin
         dec_idx_s = ((s_paddr >= START_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                      (s_paddr <= END_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) ? IW'(i) : dec_idx_s;
         hit_s     = hit_s | ((s_paddr >= START_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                              (s_paddr <= END_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]));
      end
   end

   // Next-state and routing/response outputs
   always_comb begin
      state_nxt_s = state_r;
      m_psel      = '0;
      m_penable   = '0;
      s_prdata    = '0;
      s_pready    = 1'b0;
      s_pslverr   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (s_psel && !s_penable) begin
               // Gated by reset so the setup select stays low while held in reset
               m_psel[dec_idx_s] = hit_s & HRESETn;
               state_nxt_s       = ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!s_psel) begin
               state_nxt_s = ST_IDLE;
            end else if (miss_r) begin
               if (s_penable) begin
                  s_pready    = 1'b1;
                  s_pslverr   = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_ACCESS;
               end
            end else begin
               m_psel[idx_r]    = 1'b1;
               m_penable[idx_r] = s_penable;
               if (s_penable) begin
                  s_prdata  = sel_rdata_s;
                  s_pready  = sel_rdy_s;
                  s_pslverr = sel_err_s;
                  if (sel_rdy_s) begin
                     state_nxt_s = ST_IDLE;
                  end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LIM)) begin
                     state_nxt_s = ST_ABORT;
                  end else begin
                     state_nxt_s = ST_ACCESS;
                  end
               end else begin
                  state_nxt_s = ST_ACCESS;
               end
            end
         end
         ST_ABORT: begin
            s_pready    = 1'b1;
            s_pslverr   = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, latched target slot and saturating wait counter
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r <= ST_IDLE;
         idx_r   <= '0;
         miss_r  <= 1'b0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && s_psel && !s_penable) begin
            idx_r  <= dec_idx_s;
            miss_r <= ~hit_s;
         end else begin
            idx_r  <= idx_r;
            miss_r <= miss_r;
         end
         if (state_nxt_s != ST_ACCESS) begin
            cnt_r <= '0;
         end else if ((state_r == ST_ACCESS) && s_penable && !miss_r && !sel_rdy_s &&
                      (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

`ifdef APB_NODE_ERR_CAPTURE_EN
   logic err_evt_s;
   assign err_evt_s = ((state_r == ST_ACCESS) && s_psel && s_penable && miss_r) ||
                      (state_r == ST_ABORT);

   // Sticky first-error capture; a capture in the clear cycle takes priority
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_valid_o   <= 1'b0;
         err_addr_o    <= '0;
         err_timeout_o <= 1'b0;
      end else if (err_evt_s && (!err_valid_o || err_clr_i)) begin
         err_valid_o   <= 1'b1;
         err_addr_o    <= s_paddr;
         err_timeout_o <= (state_r == ST_ABORT);
      end else if (err_clr_i) begin
         err_valid_o   <= 1'b0;
         err_addr_o    <= err_addr_o;
         err_timeout_o <= err_timeout_o;
      end else begin
         err_valid_o   <= err_valid_o;
         err_addr_o    <= err_addr_o;
         err_timeout_o <= err_timeout_o;
      end
   end
`endif

endmodule

// File: tb/tb_apb_node_timeout.sv
// Directed bench for apb_node_timeout: table of single transfers plus hand
// sequences for watchdog abort, psel drop and mid-transfer reset.
module tb_apb_node_timeout;

   localparam int NB = 10;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] s_paddr;
   logic [DW-1:0] s_pwdata;
   logic          s_pwrite;
   logic          s_psel;
   logic          s_penable;
   logic [DW-1:0] s_prdata;
   logic          s_pready;
   logic          s_pslverr;
   logic [AW-1:0] m_paddr;
   logic [DW-1:0] m_pwdata;
   logic          m_pwrite;
   logic [NB-1:0] m_psel;
   logic [NB-1:0] m_penable;
   logic [NB*DW-1:0] m_prdata;
   logic [NB-1:0] m_pready;
   logic [NB-1:0] m_pslverr;
`ifdef APB_NODE_ERR_CAPTURE_EN
   logic          err_valid;
   logic [AW-1:0] err_addr;
   logic          err_timeout;
   logic          err_clr;
`endif

   int checks   = 0;
   int failures = 0;

   apb_node_timeout #(
      .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
`ifdef APB_NODE_ERR_CAPTURE_EN
      .err_valid_o(err_valid), .err_addr_o(err_addr),
      .err_timeout_o(err_timeout), .err_clr_i(err_clr),
`endif
      .HCLK(clk), .HRESETn(rst_n),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
      .s_psel(s_psel), .s_penable(s_penable),
      .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
      .m_psel(m_psel), .m_penable(m_penable),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      int          slot;       // -1 = unmapped
      logic [31:0] rdata;      // what the target slave returns
      logic        err;        // slave pslverr on its ready cycle
      int          waits;      // slave wait states
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Target slave gets the given values; every other slave gets the opposite
   task automatic drive_slaves(input int slot, input logic rdy, input logic [31:0] rd, input logic err);
      for (int i = 0; i < NB; i++) begin
         m_prdata[i*DW +: DW] = (i == slot) ? rd : ~rd;
         m_pready[i]          = (i == slot) ? rdy : ~rdy;
         m_pslverr[i]         = (i == slot) ? err : ~err;
      end
   endtask

   function automatic logic [NB-1:0] onehot(input int slot);
      logic [NB-1:0] v;
      v = '0;
      if (slot >= 0) v[slot] = 1'b1;
      else v = '0;
      return v;
   endfunction

   // Runs setup + access phases; returns just after the completing edge
   task automatic run_xfer(input int n, input vec_t v);
      logic [NB-1:0] es;
      es = onehot(v.slot);
      s_paddr = v.addr; s_pwrite = v.write; s_pwdata = v.wdata;
      s_psel = 1'b1; s_penable = 1'b0;
      drive_slaves(v.slot, 1'b0, v.rdata, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_setup_psel", n), 64'(m_psel), 64'(es));
      chk($sformatf("v%0d_setup_pen", n), 64'(m_penable), 64'd0);
      chk($sformatf("v%0d_setup_rdy", n), 64'(s_pready), 64'd0);
      @(posedge clk); #1;
      s_penable = 1'b1;
      for (int c = 0; c <= v.waits; c++) begin
         drive_slaves(v.slot, (c == v.waits), v.rdata, (c == v.waits) ? v.err : 1'b0);
         @(negedge clk);
         chk($sformatf("v%0d_c%0d_psel", n, c), 64'(m_psel), 64'(es));
         chk($sformatf("v%0d_c%0d_pen", n, c), 64'(m_penable), 64'(es));
         if (c == v.waits) begin
            chk($sformatf("v%0d_rdy", n), 64'(s_pready), 64'd1);
            chk($sformatf("v%0d_rdata", n), 64'(s_prdata), 64'(v.exp_rdata));
            chk($sformatf("v%0d_err", n), 64'(s_pslverr), 64'(v.exp_err));
         end else begin
            chk($sformatf("v%0d_c%0d_wait", n, c), 64'(s_pready), 64'd0);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vecs[0] = '{32'h1A10_3004, 1'b0, 32'h0,         3,  32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{32'h1A20_0000, 1'b1, 32'h1234_0000, -1, 32'h7777_7777, 1'b0, 0, 32'h0,         1'b1};
      vecs[2] = '{32'h1A10_0000, 1'b1, 32'hA5A5_0000, 0,  32'h0000_0000, 1'b0, 0, 32'h0000_0000, 1'b0};
      vecs[3] = '{32'h1A10_9FFC, 1'b0, 32'h0,         9,  32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0};
      vecs[4] = '{32'h1A10_2FFF, 1'b0, 32'h0,         2,  32'hCAFE_0002, 1'b1, 1, 32'hCAFE_0002, 1'b1};
      vecs[5] = '{32'h1A10_A000, 1'b0, 32'h0,         -1, 32'h5555_0000, 1'b0, 0, 32'h0,         1'b1};
      vecs[6] = '{32'h1A0F_FFFF, 1'b0, 32'h0,         -1, 32'h0F0F_0F0F, 1'b0, 0, 32'h0,         1'b1};
      vecs[7] = '{32'h1A10_7000, 1'b0, 32'h0,         7,  32'h0BAD_F00D, 1'b0, 3, 32'h0BAD_F00D, 1'b0};
      vecs[8] = '{32'h1A10_2010, 1'b0, 32'h0,         2,  32'hB0B0_0002, 1'b1, 7, 32'hB0B0_0002, 1'b1};
      vecs[9] = '{32'h1A10_2020, 1'b0, 32'h0,         2,  32'hB0B0_1002, 1'b0, 7, 32'hB0B0_1002, 1'b0};

`ifdef APB_NODE_ERR_CAPTURE_EN
      err_clr = 1'b0;
`endif
      // Reset with a setup phase presented: nothing may leak out
      rst_n = 1'b0;
      s_paddr = 32'h1A10_3000; s_pwdata = '0; s_pwrite = 1'b0;
      s_psel = 1'b1; s_penable = 1'b0;
      drive_slaves(3, 1'b1, 32'h1111_2222, 1'b1);
      #3;
      chk("rst_psel", 64'(m_psel), 64'd0);
      chk("rst_pen", 64'(m_penable), 64'd0);
      chk("rst_rdy", 64'(s_pready), 64'd0);
      chk("rst_err", 64'(s_pslverr), 64'd0);
      chk("rst_rdata", 64'(s_prdata), 64'd0);
      s_psel = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back table: no idle cycles between entries
      for (int n = 0; n < 10; n++) run_xfer(n, vecs[n]);

      // Watchdog: slave 5 never ready -> ABORT after 8 access cycles
      s_paddr = 32'h1A10_5000; s_psel = 1'b1; s_penable = 1'b0;
      drive_slaves(5, 1'b0, 32'h55AA_55AA, 1'b0);
      @(negedge clk);
      chk("to_setup_psel", 64'(m_psel), 64'(onehot(5)));
      @(posedge clk); #1;
      s_penable = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("to_c%0d_psel", c), 64'(m_psel), 64'(onehot(5)));
         chk($sformatf("to_c%0d_rdy", c), 64'(s_pready), 64'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("abort_psel", 64'(m_psel), 64'd0);
      chk("abort_pen", 64'(m_penable), 64'd0);
      chk("abort_rdy", 64'(s_pready), 64'd1);
      chk("abort_err", 64'(s_pslverr), 64'd1);
      chk("abort_rdata", 64'(s_prdata), 64'd0);
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0;
      drive_slaves(5, 1'b1, 32'h55AA_55AA, 1'b0);
      @(negedge clk);
      chk("late_rdy_ignored", 64'(s_pready), 64'd0);
      chk("late_psel", 64'(m_psel), 64'd0);
      @(posedge clk); #1;

      // Upstream drops psel mid-access: no response, counter must restart
      s_paddr = 32'h1A10_6000; s_psel = 1'b1; s_penable = 1'b0;
      drive_slaves(6, 1'b0, 32'h6666_0000, 1'b0);
      @(posedge clk); #1;
      s_penable = 1'b1;
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0;
      @(negedge clk);
      chk("drop_rdy", 64'(s_pready), 64'd0);
      @(posedge clk); #1;
      run_xfer(20, '{32'h1A10_6004, 1'b0, 32'h0, 6, 32'h6666_0001, 1'b0, 7, 32'h6666_0001, 1'b0});
      s_psel = 1'b0; s_penable = 1'b0;

`ifdef APB_NODE_ERR_CAPTURE_EN
      chk("cap_valid", 64'(err_valid), 64'd1);
      chk("cap_addr", 64'(err_addr), 64'h1A20_0000);
      chk("cap_timeout", 64'(err_timeout), 64'd0);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("cap_cleared", 64'(err_valid), 64'd0);
`endif

      // Reset in the middle of a slave-4 access
      s_paddr = 32'h1A10_4000; s_psel = 1'b1; s_penable = 1'b0;
      drive_slaves(4, 1'b0, 32'h4444_4444, 1'b0);
      @(posedge clk); #1;
      s_penable = 1'b1;
      @(negedge clk);
      chk("mid_pen", 64'(m_penable), 64'(onehot(4)));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", 64'(m_psel), 64'd0);
      chk("mid_rst_pen", 64'(m_penable), 64'd0);
      chk("mid_rst_rdy", 64'(s_pready), 64'd0);
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_xfer(30, '{32'h1A10_1010, 1'b1, 32'hFEED_0001, 1, 32'h1111_0001, 1'b0, 1, 32'h1111_0001, 1'b0});
      s_psel = 1'b0; s_penable = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
